// File: rtl/kbd_arb_pkg.sv
// Shared types, ASCII constants and the injected-character filter for kbd_source_arbiter.
// Optional build macro KBD_UPCASE_EN: map 'a'..'z' to 'A'..'Z' before presentation.
package kbd_arb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        START,
        FETCH,
        FETCH_WAIT,
        PRESENT,
        GAP,
        SKIP,
        NEXT
    } arb_state_t;

    localparam logic [6:0] CR  = 7'h0D;
    localparam logic [6:0] LF  = 7'h0A;
    localparam logic [6:0] ESC = 7'h1B;
    localparam logic [6:0] DEL = 7'h7F;

    // Filter verdict: emit=0 means the byte is skipped.
    typedef struct packed {
        logic       emit;
        logic [6:0] ch;
    } filt_t;

    // Lower-to-upper case folding when the monitor only understands uppercase.
    function automatic logic [6:0] opt_upcase(input logic [6:0] c);
        logic [6:0] r;
        r = c;
`ifdef KBD_UPCASE_EN
        if (c >= 7'h61 && c <= 7'h7A) r = c - 7'h20;
`endif
        return r;
    endfunction

    // Bit7 is dropped; CR and LF both become CR, except LF straight after CR (CRLF -> one CR).
    function automatic filt_t char_filter(input logic [7:0] raw, input logic prev_cr);
        logic [7:0] b;
        filt_t      f;
        b      = raw & 8'h7F;
        f.emit = 1'b1;
        f.ch   = opt_upcase(b[6:0]);
        if (b == {1'b0, CR}) begin
            f.ch = CR;
        end else if (b == {1'b0, LF}) begin
            f.ch   = CR;
            f.emit = !prev_cr;
        end else if (b < 8'h20 || b == {1'b0, DEL}) begin
            f.emit = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/kbd_source_arbiter_pace_timer.sv
// Loadable down-counter that paces injected characters; stops at zero.
module kbd_pace_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk25_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic         zero_q;

    // Load has priority; otherwise count down once per cycle until zero.
    always_ff @(posedge clk25_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (!zero_q) begin
            cnt_q  <= cnt_q - W'(1);
            zero_q <= (cnt_q == W'(1));
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/kbd_source_arbiter.sv
// Shares the Apple-I KBD/KBDCR register between the PS/2 keyboard and the
// "Load Ascii" text injector, pacing injected characters on CPU read acks.
// Optional build macro KBD_UPCASE_EN (see kbd_arb_pkg::opt_upcase).
module kbd_source_arbiter
    import kbd_arb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES    = 25000,
    parameter int unsigned CR_GAP_CYCLES = 2500000,
    parameter int unsigned START_DELAY   = 250000,
    parameter int unsigned ADDR_W        = 13
) (
    input  logic              clk25_i,
    input  logic              rst_n_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    output logic [ADDR_W-1:0] txt_addr_o,
    input  logic [7:0]        txt_data_i,
    input  logic              ps2_valid_i,
    input  logic [6:0]        ps2_ascii_i,
    input  logic              kbd_ack_i,
    output logic [6:0]        kbd_data_o,
    output logic              kbd_strobe_o,
    output logic              inject_busy_o
);

    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned TMR_MX1 = (CR_GAP_CYCLES > START_DELAY) ? CR_GAP_CYCLES : START_DELAY;
    localparam int unsigned TMR_MAX = (TMR_MX1 > GAP_CYCLES) ? TMR_MX1 : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    arb_state_t        state_q;
    logic              dl_active_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] txt_addr_q;
    logic [6:0]        kbd_data_q;
    logic              strobe_q;
    logic              busy_q;
    logic [6:0]        held_q;
    logic              held_vld_q;
    logic [6:0]        pend_ch_q;
    logic              shown_q;
    logic              abort_q;
    logic              prev_cr_q;

    logic              dl_rise_c;
    logic              ack_c;
    logic              esc_c;
    logic [6:0]        key_c;
    filt_t             filt_c;
    logic [LEN_W-1:0]  addr_inc_c;
    logic              start_go_c;
    logic              gap_go_c;
    logic              tmr_load_c;
    logic [TMR_W-1:0]  tmr_val_c;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_zero;

    // Decodes shared by the FSM and the pacing timer load.
    always_comb begin
        dl_rise_c  = dl_active_i && !dl_active_q;
        ack_c      = kbd_ack_i && strobe_q;
        esc_c      = ps2_valid_i && (ps2_ascii_i == ESC);
        key_c      = opt_upcase(ps2_ascii_i);
        filt_c     = char_filter(txt_data_i, prev_cr_q);
        addr_inc_c = LEN_W'(txt_addr_q) + LEN_W'(1);
        start_go_c = (state_q == LOAD) && !dl_active_i && (len_q != '0);
        gap_go_c   = (state_q == PRESENT) && shown_q && ack_c && !abort_q && !esc_c && !dl_rise_c;
        tmr_load_c = start_go_c || gap_go_c;
        if (start_go_c)
            tmr_val_c = TMR_W'(START_DELAY);
        else if (pend_ch_q == CR)
            tmr_val_c = TMR_W'(CR_GAP_CYCLES);
        else
            tmr_val_c = TMR_W'(GAP_CYCLES);
    end

    kbd_pace_timer #(.W(TMR_W)) u_timer (
        .clk25_i    (clk25_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    // Download edge detect and file length capture (length is last address + 1).
    always_ff @(posedge clk25_i) begin
        if (!rst_n_i) begin
            dl_active_q <= 1'b0;
            len_q       <= '0;
        end else begin
            dl_active_q <= dl_active_i;
            if (dl_active_i && dl_wr_i)
                len_q <= LEN_W'(dl_addr_i) + LEN_W'(1);
            else if (dl_rise_c)
                len_q <= '0;
        end
    end

    // Arbitration FSM: PS/2 path in IDLE, paced buffer replay otherwise.
    always_ff @(posedge clk25_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            txt_addr_q <= '0;
            kbd_data_q <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            shown_q    <= 1'b0;
            abort_q    <= 1'b0;
            prev_cr_q  <= 1'b0;
        end else begin
            if (ack_c) strobe_q <= 1'b0;

            if (dl_rise_c) begin
                state_q    <= LOAD;
                busy_q     <= 1'b1;
                abort_q    <= 1'b0;
                held_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ack_c) begin
                            if (ps2_valid_i) begin
                                kbd_data_q <= key_c;
                                strobe_q   <= 1'b1;
                                held_vld_q <= 1'b0;
                            end
                        end else if (!strobe_q) begin
                            if (held_vld_q) begin
                                kbd_data_q <= held_q;
                                strobe_q   <= 1'b1;
                                held_vld_q <= ps2_valid_i;
                                if (ps2_valid_i) held_q <= key_c;
                            end else if (ps2_valid_i) begin
                                kbd_data_q <= key_c;
                                strobe_q   <= 1'b1;
                            end
                        end else if (ps2_valid_i) begin
                            held_q     <= key_c;
                            held_vld_q <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (!dl_active_i) begin
                            if (len_q == '0) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q    <= START;
                                txt_addr_q <= '0;
                                prev_cr_q  <= 1'b0;
                            end
                        end
                    end
                    START: begin
                        if (esc_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (tmr_zero) begin
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (esc_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= FETCH_WAIT;
                        end
                    end
                    FETCH_WAIT: begin
                        if (esc_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            prev_cr_q <= ((txt_data_i & 8'h7F) == {1'b0, CR});
                            pend_ch_q <= filt_c.ch;
                            shown_q   <= 1'b0;
                            state_q   <= filt_c.emit ? PRESENT : SKIP;
                        end
                    end
                    PRESENT: begin
                        // A stale unacked key may still own the strobe; wait it out first.
                        if (!shown_q) begin
                            if (esc_c) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else if (!strobe_q) begin
                                kbd_data_q <= pend_ch_q;
                                strobe_q   <= 1'b1;
                                shown_q    <= 1'b1;
                            end
                        end else begin
                            if (esc_c) abort_q <= 1'b1;
                            if (ack_c) begin
                                if (abort_q || esc_c) begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state_q <= GAP;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (esc_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (tmr_value == '0) begin
                            state_q <= NEXT;
                        end
                    end
                    SKIP: begin
                        if (esc_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (esc_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            txt_addr_q <= addr_inc_c[ADDR_W-1:0];
                            if (addr_inc_c == len_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign txt_addr_o    = txt_addr_q;
    assign kbd_data_o    = kbd_data_q;
    assign kbd_strobe_o  = strobe_q;
    assign inject_busy_o = busy_q;

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Directed bench for kbd_source_arbiter with shortened pacing constants.
module tb_kbd_source_arbiter;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned GAP    = 4;
    localparam int unsigned CRGAP  = 40;
    localparam int unsigned STARTD = 20;

    logic              clk25;
    logic              rst_n;
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [ADDR_W-1:0] txt_addr;
    logic [7:0]        txt_data;
    logic              ps2_valid;
    logic [6:0]        ps2_ascii;
    logic              kbd_ack;
    logic [6:0]        kbd_data;
    logic              kbd_strobe;
    logic              inject_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] dl_q [$];
    logic [6:0] got [$];
    int         gaps [$];
    int         tail;
    logic       timed_out;

    kbd_source_arbiter #(
        .GAP_CYCLES    (GAP),
        .CR_GAP_CYCLES (CRGAP),
        .START_DELAY   (STARTD),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk25_i       (clk25),
        .rst_n_i       (rst_n),
        .dl_active_i   (dl_active),
        .dl_wr_i       (dl_wr),
        .dl_addr_i     (dl_addr),
        .txt_addr_o    (txt_addr),
        .txt_data_i    (txt_data),
        .ps2_valid_i   (ps2_valid),
        .ps2_ascii_i   (ps2_ascii),
        .kbd_ack_i     (kbd_ack),
        .kbd_data_o    (kbd_data),
        .kbd_strobe_o  (kbd_strobe),
        .inject_busy_o (inject_busy)
    );

    initial begin
        clk25 = 1'b0;
        forever #5 clk25 = ~clk25;
    end

    // Text buffer model: one-cycle read latency.
    always @(posedge clk25) txt_data <= mem[txt_addr];

    task automatic download();
        @(negedge clk25);
        dl_active = 1'b1;
        @(negedge clk25);
        foreach (dl_q[i]) begin
            mem[i]  = dl_q[i];
            dl_wr   = 1'b1;
            dl_addr = ADDR_W'(i);
            @(negedge clk25);
            dl_wr = 1'b0;
        end
        @(negedge clk25);
        dl_active = 1'b0;
    endtask

    task automatic pulse_key(input logic [6:0] k);
        ps2_ascii = k;
        ps2_valid = 1'b1;
        @(negedge clk25);
        ps2_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        kbd_ack = 1'b1;
        @(negedge clk25);
        kbd_ack = 1'b0;
    endtask

    // Acts as the CPU: records each strobed char, acks it 2 cycles later, and
    // measures cycles from each ack to the next strobe / end of busy.
    task automatic collect(input int budget, input int stop_at);
        int cyc;
        int since_ack;
        got.delete();
        gaps.delete();
        timed_out = 1'b0;
        tail      = -1;
        cyc       = 0;
        since_ack = -1;
        forever begin
            @(negedge clk25);
            cyc++;
            if (since_ack >= 0) since_ack++;
            if (cyc > budget) begin
                timed_out = 1'b1;
                return;
            end
            if (kbd_strobe) begin
                got.push_back(kbd_data);
                gaps.push_back(since_ack);
                if (stop_at != 0 && got.size() == stop_at) return;
                repeat (2) @(negedge clk25);
                kbd_ack = 1'b1;
                @(negedge clk25);
                kbd_ack   = 1'b0;
                cyc      += 3;
                since_ack = 0;
            end else if (!inject_busy) begin
                tail = since_ack;
                return;
            end
        end
    endtask

    function automatic logic [6:0] got_at(input int i);
        return (got.size() > i) ? got[i] : 7'h00;
    endfunction

    function automatic int gap_at(input int i);
        return (gaps.size() > i) ? gaps[i] : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk25);
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", kbd_strobe); end
        total++; if (kbd_data !== 7'h00) begin bad++; $display("FAIL reset_data got=%h want=00", kbd_data); end
        total++; if (txt_addr !== '0) begin bad++; $display("FAIL reset_txt_addr got=%h want=0", txt_addr); end
        total++; if (inject_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", inject_busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk25);
    endtask

    task automatic test_hi_crlf();
        dl_q = '{8'h48, 8'h49, 8'h0D, 8'h0A};
        download();
        total++; if (inject_busy !== 1'b1) begin bad++; $display("FAIL hi_busy_after_dl got=%b want=1", inject_busy); end
        collect(3000, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL hi_timeout got=%b want=0", timed_out); end
        total++; if (got.size() != 3) begin bad++; $display("FAIL hi_count got=%0d want=3", got.size()); end
        total++; if (got_at(0) !== 7'h48) begin bad++; $display("FAIL hi_c0 got=%h want=48", got_at(0)); end
        total++; if (got_at(1) !== 7'h49) begin bad++; $display("FAIL hi_c1 got=%h want=49", got_at(1)); end
        total++; if (got_at(2) !== 7'h0D) begin bad++; $display("FAIL hi_c2 got=%h want=0d", got_at(2)); end
        total++; if (gap_at(1) < GAP || gap_at(1) > GAP + 8) begin bad++; $display("FAIL hi_gap1 got=%0d want=%0d..%0d", gap_at(1), GAP, GAP + 8); end
        total++; if (tail < CRGAP || tail > CRGAP + 8) begin bad++; $display("FAIL hi_cr_tail got=%0d want=%0d..%0d", tail, CRGAP, CRGAP + 8); end
        repeat (20) @(negedge clk25);
        total++; if (kbd_strobe !== 1'b0 || inject_busy !== 1'b0) begin bad++; $display("FAIL hi_quiet got=%b%b want=00", kbd_strobe, inject_busy); end
    endtask

    task automatic test_lf_only();
        dl_q = '{8'h41, 8'h0A, 8'h42};
        download();
        collect(3000, 0);
        total++; if (got.size() != 3) begin bad++; $display("FAIL lf_count got=%0d want=3", got.size()); end
        total++; if (got_at(0) !== 7'h41) begin bad++; $display("FAIL lf_c0 got=%h want=41", got_at(0)); end
        total++; if (got_at(1) !== 7'h0D) begin bad++; $display("FAIL lf_c1 got=%h want=0d", got_at(1)); end
        total++; if (got_at(2) !== 7'h42) begin bad++; $display("FAIL lf_c2 got=%h want=42", got_at(2)); end
        total++; if (gap_at(2) < CRGAP || gap_at(2) > CRGAP + 8) begin bad++; $display("FAIL lf_cr_gap got=%0d want=%0d..%0d", gap_at(2), CRGAP, CRGAP + 8); end
    endtask

    task automatic test_filter();
        dl_q = '{8'h21, 8'h01, 8'h7F, 8'hC1, 8'h0D, 8'h0A, 8'h0A};
        download();
        collect(3000, 0);
        total++; if (got.size() != 4) begin bad++; $display("FAIL filt_count got=%0d want=4", got.size()); end
        total++; if (got_at(0) !== 7'h21) begin bad++; $display("FAIL filt_c0 got=%h want=21", got_at(0)); end
        total++; if (got_at(1) !== 7'h41) begin bad++; $display("FAIL filt_bit7 got=%h want=41", got_at(1)); end
        total++; if (got_at(2) !== 7'h0D) begin bad++; $display("FAIL filt_cr got=%h want=0d", got_at(2)); end
        total++; if (got_at(3) !== 7'h0D) begin bad++; $display("FAIL filt_lflf got=%h want=0d", got_at(3)); end
    endtask

    task automatic test_ps2_hold();
        pulse_key(7'h31);
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h31) begin bad++; $display("FAIL ps2_first got=%b/%h want=1/31", kbd_strobe, kbd_data); end
        pulse_key(7'h32);
        total++; if (kbd_data !== 7'h31) begin bad++; $display("FAIL ps2_held_keep got=%h want=31", kbd_data); end
        pulse_ack();
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL ps2_ack_clear got=%b want=0", kbd_strobe); end
        @(negedge clk25);
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h32) begin bad++; $display("FAIL ps2_held_out got=%b/%h want=1/32", kbd_strobe, kbd_data); end
        pulse_key(7'h33);
        pulse_key(7'h34);
        pulse_ack();
        @(negedge clk25);
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h34) begin bad++; $display("FAIL ps2_overwrite got=%b/%h want=1/34", kbd_strobe, kbd_data); end
        pulse_ack();
        repeat (3) @(negedge clk25);
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL ps2_empty got=%b want=0", kbd_strobe); end
        pulse_key(7'h35);
        kbd_ack   = 1'b1;
        ps2_ascii = 7'h36;
        ps2_valid = 1'b1;
        @(negedge clk25);
        kbd_ack   = 1'b0;
        ps2_valid = 1'b0;
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h36) begin bad++; $display("FAIL ps2_simul got=%b/%h want=1/36", kbd_strobe, kbd_data); end
        pulse_ack();
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL ps2_simul_clear got=%b want=0", kbd_strobe); end
    endtask

    task automatic test_esc_abort();
        int strobes;
        dl_q.delete();
        for (int i = 0; i < 100; i++) dl_q.push_back(8'h41 + 8'(i % 26));
        download();
        collect(3000, 3);
        total++; if (got_at(2) !== 7'h43) begin bad++; $display("FAIL esc_c3 got=%h want=43", got_at(2)); end
        pulse_key(7'h41);
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h43) begin bad++; $display("FAIL esc_nonesc got=%b/%h want=1/43", kbd_strobe, kbd_data); end
        collect(3000, 3);
        total++; if (got_at(1) !== 7'h44) begin bad++; $display("FAIL esc_c4 got=%h want=44", got_at(1)); end
        total++; if (got_at(2) !== 7'h45) begin bad++; $display("FAIL esc_c5 got=%h want=45", got_at(2)); end
        pulse_key(7'h1B);
        total++; if (kbd_strobe !== 1'b1 || inject_busy !== 1'b1 || kbd_data !== 7'h45) begin bad++; $display("FAIL esc_hold got=%b%b/%h want=11/45", kbd_strobe, inject_busy, kbd_data); end
        pulse_ack();
        total++; if (inject_busy !== 1'b0 || kbd_strobe !== 1'b0) begin bad++; $display("FAIL esc_idle got=%b%b want=00", inject_busy, kbd_strobe); end
        strobes = 0;
        repeat (300) begin
            @(negedge clk25);
            if (kbd_strobe || inject_busy) strobes++;
        end
        total++; if (strobes != 0) begin bad++; $display("FAIL esc_no_resume got=%0d want=0", strobes); end
    endtask

    task automatic test_reset_mid();
        int active;
        dl_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        download();
        collect(3000, 2);
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h31) begin bad++; $display("FAIL rst_pre got=%b/%h want=1/31", kbd_strobe, kbd_data); end
        rst_n = 1'b0;
        @(negedge clk25);
        rst_n = 1'b1;
        total++; if (kbd_strobe !== 1'b0 || inject_busy !== 1'b0 || txt_addr !== '0) begin bad++; $display("FAIL rst_mid got=%b%b/%h want=00/00", kbd_strobe, inject_busy, txt_addr); end
        active = 0;
        repeat (300) begin
            @(negedge clk25);
            if (kbd_strobe || inject_busy) active++;
        end
        total++; if (active != 0) begin bad++; $display("FAIL rst_no_resume got=%0d want=0", active); end
    endtask

    task automatic test_dl_abort();
        dl_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        download();
        collect(3000, 2);
        dl_q = '{8'h51};
        download();
        total++; if (kbd_strobe !== 1'b1 || kbd_data !== 7'h31 || inject_busy !== 1'b1) begin bad++; $display("FAIL dlab_keep got=%b%b/%h want=11/31", kbd_strobe, inject_busy, kbd_data); end
        pulse_ack();
        collect(3000, 0);
        total++; if (got.size() != 1 || got_at(0) !== 7'h51) begin bad++; $display("FAIL dlab_new got=%0d/%h want=1/51", got.size(), got_at(0)); end
    endtask

    task automatic test_wrap();
        dl_q.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) dl_q.push_back(8'h30 + 8'(i % 10));
        download();
        collect(8000, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL wrap_timeout got=%b want=0", timed_out); end
        total++; if (got.size() != (1 << ADDR_W)) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", got.size(), 1 << ADDR_W); end
        total++; if (got_at((1 << ADDR_W) - 1) !== 7'h37) begin bad++; $display("FAIL wrap_last got=%h want=37", got_at((1 << ADDR_W) - 1)); end
    endtask

    task automatic test_upcase();
        logic [6:0] ea;
        logic [6:0] eb;
`ifdef KBD_UPCASE_EN
        ea = 7'h41;
        eb = 7'h42;
`else
        ea = 7'h61;
        eb = 7'h62;
`endif
        dl_q = '{8'h61, 8'h62};
        download();
        collect(3000, 0);
        total++; if (got_at(0) !== ea || got_at(1) !== eb || got.size() != 2) begin bad++; $display("FAIL upcase_inj got=%h%h want=%h%h", got_at(0), got_at(1), ea, eb); end
        pulse_key(7'h61);
        total++; if (kbd_data !== ea) begin bad++; $display("FAIL upcase_ps2 got=%h want=%h", kbd_data, ea); end
        pulse_ack();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        ps2_valid = 1'b0;
        ps2_ascii = '0;
        kbd_ack   = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        test_reset();
        test_hi_crlf();
        test_lf_only();
        test_filter();
        test_ps2_hold();
        test_esc_abort();
        test_reset_mid();
        test_dl_abort();
        test_wrap();
        test_upcase();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
